// File: rtl/answer_token_emitter.sv
// Converts a 32-bit result into most-significant-first decimal tokens
// (optional leading minus) using double-dabble, with a valid/ready output.
module answer_token_emitter #(
  parameter bit         SIGNED      = 1'b1,
  parameter logic [3:0] MINUS_TOKEN = 4'hB
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] number,
  output logic [3:0]  token,
  output logic        token_valid,
  input  logic        token_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CONVERT, FIND, SIGN, EMIT} state_t;

  state_t      state_q, state_d;
  logic        neg_q, neg_d;
  logic [31:0] mag_q, mag_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [3:0]  token_q, token_d;
  logic        token_valid_q, token_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        xfer;
  logic [3:0]  msd;

  function automatic logic [39:0] dabble_adjust(input logic [39:0] b);
    logic [39:0] r;
    r = b;
    for (int i = 0; i < 10; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [3:0] digit_at(input logic [39:0] b, input logic [3:0] idx);
    logic [39:0] s;
    s = b >> {idx, 2'b00};
    return s[3:0];
  endfunction

  function automatic logic [3:0] msd_index(input logic [39:0] b);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (b[i*4 +: 4] != 4'd0) r = 4'(i);
    end
    return r;
  endfunction

  assign xfer = token_valid_q && token_ready;
  assign msd  = msd_index(bcd_q);

  always_comb begin
    logic [39:0] adj;
    state_d       = state_q;
    neg_d         = neg_q;
    mag_d         = mag_q;
    bcd_d         = bcd_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    token_d       = token_q;
    token_valid_d = token_valid_q;
    done_d        = 1'b0;
    adj           = dabble_adjust(bcd_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d   = SIGNED && number[31];
          mag_d   = (SIGNED && number[31]) ? (~number + 32'd1) : number;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {adj[38:0], mag_q[31]};
        mag_d = {mag_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIND;
      end
      FIND: begin
        ptr_d         = msd;
        token_valid_d = 1'b1;
        if (neg_q) begin
          state_d = SIGN;
          token_d = MINUS_TOKEN;
        end else begin
          state_d = EMIT;
          token_d = digit_at(bcd_q, msd);
        end
      end
      SIGN: begin
        if (xfer) begin
          state_d = EMIT;
          token_d = digit_at(bcd_q, ptr_q);
        end
      end
      EMIT: begin
        if (xfer) begin
          if (ptr_q != 4'd0) begin
            ptr_d   = ptr_q - 4'd1;
            token_d = digit_at(bcd_q, ptr_q - 4'd1);
          end else begin
            state_d       = IDLE;
            token_d       = 4'd0;
            token_valid_d = 1'b0;
            done_d        = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      neg_q         <= 1'b0;
      mag_q         <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      ptr_q         <= '0;
      token_q       <= '0;
      token_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      neg_q         <= neg_d;
      mag_q         <= mag_d;
      bcd_q         <= bcd_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      token_q       <= token_d;
      token_valid_q <= token_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign token       = token_q;
  assign token_valid = token_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_answer_token_emitter.sv
// Bench for answer_token_emitter: a signed and an unsigned instance, a queue
// scoreboard fed from a decimal-arithmetic reference, and a handshake monitor.
module tb_answer_token_emitter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        token_ready = 1'b1;
  logic [31:0] number = '0;
  logic        start [2];
  logic [3:0]  tok   [2];
  logic        tv    [2];
  logic        busy  [2];
  logic        done  [2];

  logic [3:0]  exp_q [2][$];
  int          xfer  [2];
  bit          stall [2];
  logic [3:0]  ptok  [2];
  bit          rand_rdy = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  answer_token_emitter #(.SIGNED(1'b1), .MINUS_TOKEN(4'hB)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .number(number),
    .token(tok[0]), .token_valid(tv[0]), .token_ready(token_ready),
    .busy(busy[0]), .done(done[0]));

  answer_token_emitter #(.SIGNED(1'b0), .MINUS_TOKEN(4'hB)) dut_u (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .number(number),
    .token(tok[1]), .token_valid(tv[1]), .token_ready(token_ready),
    .busy(busy[1]), .done(done[1]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  // Reference: decimal digits by repeated division on the magnitude.
  function automatic int push_exp(input int i, input logic [31:0] num);
    longint unsigned m;
    logic [3:0] digs[$];
    bit neg;
    int n;
    neg = (i == 0) && num[31];
    m   = neg ? (64'h1_0000_0000 - 64'(num)) : 64'(num);
    do begin
      digs.push_front(4'(m % 10));
      m = m / 10;
    end while (m != 0);
    n = digs.size();
    if (neg) begin
      exp_q[i].push_back(4'hB);
      n++;
    end
    foreach (digs[k]) exp_q[i].push_back(digs[k]);
    return n;
  endfunction

  always @(negedge clk) begin
    logic [3:0] e;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        stall[i] = 1'b0;
      end else begin
        if (stall[i]) begin
          chk("stall_valid", 32'(tv[i]), 32'd1);
          chk("stall_token", 32'(tok[i]), 32'(ptok[i]));
        end
        if (!tv[i]) chk("idle_token_zero", 32'(tok[i]), 32'd0);
        if (tv[i] && token_ready) begin
          if (exp_q[i].size() == 0) begin
            chk("unexpected_token", 32'(tok[i]), 32'hFFFF);
          end else begin
            e = exp_q[i].pop_front();
            chk("token", 32'(tok[i]), 32'(e));
          end
          xfer[i]++;
        end
        if (done[i]) chk("done_queue_empty", 32'(exp_q[i].size()), 32'd0);
        stall[i] = tv[i] && !token_ready;
        ptok[i]  = tok[i];
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      token_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_cmd(input int i, input logic [31:0] num, output int ntok);
    int k;
    k = 0;
    while (busy[i] && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (busy[i]) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    number   = num;
    start[i] = 1'b1;
    ntok     = push_exp(i, num);
    @(posedge clk);
    #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input bit gap_chk, input int ntok);
    int k;
    int vc;
    k  = 0;
    vc = 0;
    while (k < 500) begin
      @(negedge clk);
      if (done[i]) break;
      if (tv[i]) vc++;
      k++;
    end
    chk("done_seen", 32'(done[i]), 32'd1);
    chk("done_busy_low", 32'(busy[i]), 32'd0);
    if (gap_chk) chk("consecutive_tokens", 32'(vc), 32'(ntok));
    @(negedge clk);
    chk("done_one_cycle", 32'(done[i]), 32'd0);
  endtask

  task automatic run(input int i, input logic [31:0] num, input bit gap_chk);
    int n;
    start_cmd(i, num, n);
    wait_done(i, gap_chk, n);
  endtask

  task automatic wait_xfer(input int i, input int target);
    int k;
    k = 0;
    while (xfer[i] < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (xfer[i] < target) chk("xfer_timeout", 32'(xfer[i]), 32'(target));
  endtask

  initial begin
    int n;
    int lat;
    int base;
    logic [31:0] num;
    start[0] = 1'b0;
    start[1] = 1'b0;
    xfer[0]  = 0;
    xfer[1]  = 0;
    #23;
    for (int i = 0; i < 2; i++) begin
      chk("rst_token", 32'(tok[i]), 32'd0);
      chk("rst_valid", 32'(tv[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_done", 32'(done[i]), 32'd0);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Zero input: latency to first token, single token, done/busy timing.
    start_cmd(0, 32'd0, n);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (tv[0]) break;
    end
    chk("zero_first_valid_latency", 32'(lat), 32'd34);
    chk("zero_busy_while_valid", 32'(busy[0]), 32'd1);
    @(negedge clk);
    chk("zero_done", 32'(done[0]), 32'd1);
    chk("zero_busy_falls", 32'(busy[0]), 32'd0);
    @(negedge clk);
    chk("zero_done_one_cycle", 32'(done[0]), 32'd0);

    run(0, 32'd12345, 1'b1);
    run(0, 32'hFFFF_FFF9, 1'b1);
    run(0, 32'h8000_0000, 1'b1);
    run(1, 32'hFFFF_FFFF, 1'b1);
    run(1, 32'h8000_0000, 1'b1);
    run(0, 32'd1000000000, 1'b1);

    // Backpressure while the second token is presented.
    base = xfer[0];
    start_cmd(0, 32'd1002, n);
    wait_xfer(0, base + 1);
    @(posedge clk);
    #1;
    token_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("bp_held_token", 32'(tok[0]), 32'd0);
    chk("bp_held_valid", 32'(tv[0]), 32'd1);
    token_ready = 1'b1;
    wait_done(0, 1'b0, n);

    // Start while busy must be ignored.
    base = xfer[0];
    start_cmd(0, 32'd12345678, n);
    wait_xfer(0, base + 2);
    @(posedge clk);
    #1;
    number   = 32'd999;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    wait_done(0, 1'b0, n);

    // Reset in the middle of the token stream.
    base = xfer[1];
    start_cmd(1, 32'hFFFF_FFFF, n);
    wait_xfer(1, base + 3);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("abort_token", 32'(tok[i]), 32'd0);
      chk("abort_valid", 32'(tv[i]), 32'd0);
      chk("abort_busy", 32'(busy[i]), 32'd0);
      chk("abort_done", 32'(done[i]), 32'd0);
      exp_q[i].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run(1, 32'd4056, 1'b1);
    run(0, 32'hFFFF_F000, 1'b1);

    // Randomized numbers with random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       num = $urandom;
        1:       num = $urandom_range(0, 999);
        2:       num = {1'b1, 31'($urandom)};
        default: num = $urandom_range(0, 99999);
      endcase
      run(k % 2, num, 1'b0);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    token_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_queue0_empty", 32'(exp_q[0].size()), 32'd0);
    chk("final_queue1_empty", 32'(exp_q[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
